peak_packer: RTL and testbench

- Consumes the per-run peak stream (valid/sop/eop, freq, phaseA, phaseB) produced by the phase-extraction chain.
- Packs each run into a byte-framed packet for the host link (UART/USB bridge) on a ready/valid byte interface.
- The input has no backpressure, so frames are ping-pong buffered; whole frames are dropped when both buffers are full.

---
 rtl/peak_packer_pkg.sv | 42 ++++
 rtl/peak_frame_buf.sv | 118 +++++++++++
 rtl/peak_packer.sv | 150 +++++++++++++++
 tb/tb_peak_packer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peak_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : peak_packer_pkg
// Brief    : Shared types, sizes and check-byte helper for the peak packer.
//            PEAK_PACKER_CRC_EN selects CRC-8 (0x07) instead of the 8-bit sum.
// Revision : 1.0 - initial release
// ============================================================================
package peak_packer_pkg;

    localparam int ENTRY_BYTES = 7;
    localparam int HDR_BYTES   = 3;

    typedef struct packed {
        logic [23:0] freq;
        logic [15:0] phase_a;
        logic [15:0] phase_b;
    } peak_entry_t;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_SYNC    = 3'd1,
        TX_SEQ     = 3'd2,
        TX_CNT     = 3'd3,
        TX_PAYLOAD = 3'd4,
        TX_CHK     = 3'd5
    } tx_state_t;

    function automatic logic [7:0] chk_next(input logic [7:0] chk, input logic [7:0] data);
`ifdef PEAK_PACKER_CRC_EN
        logic [7:0] crc;
        crc = chk ^ data;
        for (int i = 0; i < 8; i++) begin
            crc = crc[7] ? ((crc << 1) ^ 8'h07) : (crc << 1);
        end
        return crc;
`else
        return chk + data;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/peak_frame_buf.sv
`default_nettype none
// ============================================================================
// Module   : peak_frame_buf
// Brief    : Input framing plus ping-pong storage of two frames of NPEAKS
//            entries; whole frames are dropped when both buffers are full.
// Revision : 1.0 - initial release
// ============================================================================
module peak_frame_buf
    import peak_packer_pkg::*;
#(
    parameter int NPEAKS = 4,
    localparam int CNT_W = $clog2(NPEAKS + 1),
    localparam int IDX_W = (NPEAKS > 1) ? $clog2(NPEAKS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    input  logic             i_sop,
    input  logic             i_eop,
    input  peak_entry_t      i_entry,
    input  logic             i_release,
    input  logic [IDX_W-1:0] i_rd_idx,
    output peak_entry_t      o_rd_entry,
    output logic [CNT_W-1:0] o_rd_count,
    output logic             o_rd_trunc,
    output logic             o_cur_avail,
    output logic             o_next_avail,
    output logic             o_dropped
);

    localparam logic [CNT_W-1:0] C_NPEAKS = CNT_W'(NPEAKS);

    peak_entry_t      r_mem [2][NPEAKS];
    logic [1:0]       r_full;
    logic [1:0]       r_trunc;
    logic [CNT_W-1:0] r_count [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic             r_open;
    logic             r_drop;
    logic [CNT_W-1:0] r_wcnt;
    logic             r_wtrunc;
    logic             r_dropped;

    logic             w_free;
    logic             w_accept;
    logic             w_drop_eff;
    logic [CNT_W-1:0] w_idx_cnt;
    logic [IDX_W-1:0] w_widx;
    logic             w_store;
    logic [CNT_W-1:0] w_cnt_new;
    logic             w_trunc_new;
    logic             w_close;
    logic             w_commit;

    // The buffers form a depth-2 FIFO, so the write slot is only busy when both are full;
    // a release in the same cycle frees exactly that slot.
    assign w_free      = !r_full[r_wr_ptr] || (i_release && (r_rd_ptr == r_wr_ptr));
    assign w_accept    = i_valid && (i_sop || r_open);
    assign w_drop_eff  = i_sop ? !w_free : r_drop;
    assign w_idx_cnt   = i_sop ? '0 : r_wcnt;
    assign w_widx      = IDX_W'(w_idx_cnt);
    assign w_store     = w_accept && !w_drop_eff && (w_idx_cnt < C_NPEAKS);
    assign w_cnt_new   = w_store ? (w_idx_cnt + CNT_W'(1)) : w_idx_cnt;
    assign w_trunc_new = (i_sop ? 1'b0 : r_wtrunc) | (w_idx_cnt >= C_NPEAKS);
    assign w_close     = w_accept && i_eop;
    assign w_commit    = w_close && !w_drop_eff;

    assign o_rd_entry   = r_mem[r_rd_ptr][i_rd_idx];
    assign o_rd_count   = r_count[r_rd_ptr];
    assign o_rd_trunc   = r_trunc[r_rd_ptr];
    assign o_cur_avail  = r_full[r_rd_ptr]  || (w_commit && (r_wr_ptr == r_rd_ptr));
    assign o_next_avail = r_full[!r_rd_ptr] || (w_commit && (r_wr_ptr != r_rd_ptr));
    assign o_dropped    = r_dropped;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full     <= '0;
            r_trunc    <= '0;
            r_count[0] <= '0;
            r_count[1] <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_open     <= 1'b0;
            r_drop     <= 1'b0;
            r_wcnt     <= '0;
            r_wtrunc   <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            r_dropped <= w_close && w_drop_eff;
            if (i_release) begin
                r_full[r_rd_ptr] <= 1'b0;
                r_rd_ptr         <= !r_rd_ptr;
            end
            if (w_accept) begin
                r_open   <= !i_eop;
                r_drop   <= w_drop_eff;
                r_wcnt   <= w_cnt_new;
                r_wtrunc <= w_trunc_new;
            end
            // Placed after the release so a same-cycle refill of the freed slot wins.
            if (w_commit) begin
                r_full[r_wr_ptr]  <= 1'b1;
                r_count[r_wr_ptr] <= w_cnt_new;
                r_trunc[r_wr_ptr] <= w_trunc_new;
                r_wr_ptr          <= !r_wr_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr][w_widx] <= i_entry;
        end
    end

endmodule
`default_nettype wire

// File: rtl/peak_packer.sv
`default_nettype none
// ============================================================================
// Module   : peak_packer
// Brief    : Packs per-run peak streams into SYNC/SEQ/CNT/payload/CHK byte
//            packets. Define PEAK_PACKER_CRC_EN for a CRC-8 check byte.
// Revision : 1.0 - initial release
// ============================================================================
module peak_packer
    import peak_packer_pkg::*;
#(
    parameter int         NPEAKS = 4,
    parameter logic [7:0] SYNC   = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sink_valid,
    input  logic        sink_sop,
    input  logic        sink_eop,
    input  logic [23:0] sink_freq,
    input  logic [15:0] sink_phaseA,
    input  logic [15:0] sink_phaseB,
    input  logic        source_ready,
    output logic        source_valid,
    output logic [7:0]  source_data,
    output logic        source_sop,
    output logic        source_eop,
    output logic        dropped
);

    localparam int CNT_W = $clog2(NPEAKS + 1);
    localparam int IDX_W = (NPEAKS > 1) ? $clog2(NPEAKS) : 1;

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    logic [7:0]       r_seq;
    logic [7:0]       r_chk;
    logic [IDX_W-1:0] r_ent;
    logic [2:0]       r_bsel;

    peak_entry_t      w_entry_in;
    peak_entry_t      w_rd_entry;
    logic [CNT_W-1:0] w_rd_count;
    logic             w_rd_trunc;
    logic             w_cur_avail;
    logic             w_next_avail;
    logic             w_fire;
    logic             w_release;
    logic             w_last_byte;
    logic [7:0]       w_cnt_byte;
    logic [7:0]       w_data;

    assign w_entry_in = '{freq: sink_freq, phase_a: sink_phaseA, phase_b: sink_phaseB};

    peak_frame_buf #(.NPEAKS(NPEAKS)) u_buf (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (sink_valid),
        .i_sop        (sink_sop),
        .i_eop        (sink_eop),
        .i_entry      (w_entry_in),
        .i_release    (w_release),
        .i_rd_idx     (r_ent),
        .o_rd_entry   (w_rd_entry),
        .o_rd_count   (w_rd_count),
        .o_rd_trunc   (w_rd_trunc),
        .o_cur_avail  (w_cur_avail),
        .o_next_avail (w_next_avail),
        .o_dropped    (dropped)
    );

    assign source_valid = (r_state != TX_IDLE);
    assign source_sop   = (r_state == TX_SYNC);
    assign source_eop   = (r_state == TX_CHK);
    assign source_data  = w_data;
    assign w_fire       = source_valid && source_ready;
    assign w_release    = w_fire && (r_state == TX_CHK);
    assign w_cnt_byte   = {w_rd_trunc, 7'(w_rd_count)};
    assign w_last_byte  = (r_bsel == 3'(ENTRY_BYTES - 1)) && (r_ent == IDX_W'(w_rd_count - CNT_W'(1)));

    always_comb begin
        w_data = 8'h00;
        case (r_state)
            TX_SYNC:    w_data = SYNC;
            TX_SEQ:     w_data = r_seq;
            TX_CNT:     w_data = w_cnt_byte;
            TX_PAYLOAD: begin
                case (r_bsel)
                    3'd0:    w_data = w_rd_entry.freq[23:16];
                    3'd1:    w_data = w_rd_entry.freq[15:8];
                    3'd2:    w_data = w_rd_entry.freq[7:0];
                    3'd3:    w_data = w_rd_entry.phase_a[15:8];
                    3'd4:    w_data = w_rd_entry.phase_a[7:0];
                    3'd5:    w_data = w_rd_entry.phase_b[15:8];
                    default: w_data = w_rd_entry.phase_b[7:0];
                endcase
            end
            TX_CHK:     w_data = r_chk;
            default:    w_data = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            TX_IDLE:    if (w_cur_avail) w_state_nxt = TX_SYNC;
            TX_SYNC:    if (w_fire) w_state_nxt = TX_SEQ;
            TX_SEQ:     if (w_fire) w_state_nxt = TX_CNT;
            TX_CNT:     if (w_fire) w_state_nxt = (w_rd_count == '0) ? TX_CHK : TX_PAYLOAD;
            TX_PAYLOAD: if (w_fire && w_last_byte) w_state_nxt = TX_CHK;
            // Back-to-back packets skip IDLE when the other buffer is ready or completing now.
            TX_CHK:     if (w_fire) w_state_nxt = w_next_avail ? TX_SYNC : TX_IDLE;
            default:    w_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= TX_IDLE;
            r_seq   <= 8'h00;
            r_chk   <= 8'h00;
            r_ent   <= '0;
            r_bsel  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fire) begin
                case (r_state)
                    TX_SEQ: r_chk <= chk_next(8'h00, r_seq);
                    TX_CNT: begin
                        r_chk  <= chk_next(r_chk, w_cnt_byte);
                        r_ent  <= '0;
                        r_bsel <= 3'd0;
                    end
                    TX_PAYLOAD: begin
                        r_chk <= chk_next(r_chk, w_data);
                        if (r_bsel == 3'(ENTRY_BYTES - 1)) begin
                            r_bsel <= 3'd0;
                            r_ent  <= r_ent + IDX_W'(1);
                        end else begin
                            r_bsel <= r_bsel + 3'd1;
                        end
                    end
                    TX_CHK: r_seq <= r_seq + 8'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_peak_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_peak_packer
// Brief    : Directed table vectors plus corner sequences and a randomized
//            backpressure run against a byte-level packet model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_peak_packer;

    localparam int         NPEAKS = 4;
    localparam logic [7:0] SYNC   = 8'hA5;

    logic        clk = 1'b0;
    logic        reset;
    logic        sink_valid, sink_sop, sink_eop;
    logic [23:0] sink_freq;
    logic [15:0] sink_phaseA, sink_phaseB;
    logic        source_ready, source_valid, source_sop, source_eop, dropped;
    logic [7:0]  source_data;

    always #5 clk = ~clk;

    peak_packer #(.NPEAKS(NPEAKS), .SYNC(SYNC)) dut (
        .clk          (clk),
        .reset        (reset),
        .sink_valid   (sink_valid),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_freq    (sink_freq),
        .sink_phaseA  (sink_phaseA),
        .sink_phaseB  (sink_phaseB),
        .source_ready (source_ready),
        .source_valid (source_valid),
        .source_data  (source_data),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .dropped      (dropped)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Byte monitor, sampled on the falling edge
    typedef struct packed { logic sop; logic eop; logic [7:0] data; } rx_t;
    rx_t rx_q[$];
    rx_t p_byte;
    logic p_stall = 1'b0;
    int n_pkts  = 0;
    int n_drops = 0;
    bit rand_ready = 0;

    always @(negedge clk) begin
        if (reset) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall)
                check("hold_stable", {source_valid, source_sop, source_eop, source_data},
                      {1'b1, p_byte.sop, p_byte.eop, p_byte.data});
            if (source_valid && source_ready) begin
                rx_q.push_back('{sop: source_sop, eop: source_eop, data: source_data});
                if (source_eop) n_pkts++;
            end
            p_stall = source_valid && !source_ready;
            p_byte  = '{sop: source_sop, eop: source_eop, data: source_data};
            if (dropped) n_drops++;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 source_ready = 1'($urandom_range(0, 1));
        end
    end

    // Packet model
    logic [23:0] ef[8];
    logic [15:0] ea[8];
    logic [15:0] eb[8];
    int          ne;
    logic [7:0]  exp_pkt[$];
    logic [7:0]  pkt[$];
    rx_t         exp_all[$];

    function automatic logic [7:0] ref_chk(input logic [7:0] c, input logic [7:0] d);
`ifdef PEAK_PACKER_CRC_EN
        logic fb;
        for (int k = 7; k >= 0; k--) begin
            fb = c[7] ^ d[k];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
`else
        return 8'((int'(c) + int'(d)) % 256);
`endif
    endfunction

    task automatic build_exp(input logic [7:0] seq);
        int cnt;
        logic [7:0] c;
        cnt = (ne > NPEAKS) ? NPEAKS : ne;
        exp_pkt.delete();
        exp_pkt.push_back(SYNC);
        exp_pkt.push_back(seq);
        exp_pkt.push_back({(ne > NPEAKS) ? 1'b1 : 1'b0, 7'(cnt)});
        for (int i = 0; i < cnt; i++) begin
            exp_pkt.push_back(ef[i][23:16]);
            exp_pkt.push_back(ef[i][15:8]);
            exp_pkt.push_back(ef[i][7:0]);
            exp_pkt.push_back(ea[i][15:8]);
            exp_pkt.push_back(ea[i][7:0]);
            exp_pkt.push_back(eb[i][15:8]);
            exp_pkt.push_back(eb[i][7:0]);
        end
        c = 8'h00;
        for (int i = 1; i < exp_pkt.size(); i++) c = ref_chk(c, exp_pkt[i]);
        exp_pkt.push_back(c);
    endtask

    task automatic drive(input logic s, input logic e, input int i);
        sink_valid  = 1'b1;
        sink_sop    = s;
        sink_eop    = e;
        sink_freq   = ef[i];
        sink_phaseA = ea[i];
        sink_phaseB = eb[i];
        @(posedge clk); #1;
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < ne; i++) drive(i == 0, i == ne - 1, i);
    endtask

    task automatic rand_entries(input int n);
        ne = n;
        for (int i = 0; i < n; i++) begin
            ef[i] = 24'($urandom);
            ea[i] = 16'($urandom);
            eb[i] = 16'($urandom);
        end
    endtask

    task automatic recv_pkt(input string name);
        int t;
        bit done;
        rx_t b;
        t = 0;
        done = 0;
        pkt.delete();
        while (!done) begin
            if (rx_q.size() > 0) begin
                b = rx_q.pop_front();
                check($sformatf("%s sop%0d", name, pkt.size()), 32'(b.sop), 32'(pkt.size() == 0));
                pkt.push_back(b.data);
                done = b.eop;
            end else begin
                @(posedge clk); #1;
                t++;
                if (t > 2000) begin
                    check({name, " timeout"}, 0, 1);
                    done = 1;
                end
            end
        end
    endtask

    task automatic cmp_pkt(input string name);
        check({name, " len"}, pkt.size(), exp_pkt.size());
        for (int i = 0; i < exp_pkt.size(); i++)
            if (i < pkt.size()) check($sformatf("%s byte%0d", name, i), pkt[i], exp_pkt[i]);
    endtask

    typedef struct packed {
        logic [23:0] f;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  seq;
        logic [7:0]  chk;
    } vec_t;
    vec_t vt[5];

    initial begin : main
        int t;
        int drops0;
        int pk0;
        int sent;
        logic [7:0] seq;

        // Single-entry frames with hand-computed sum checksums
        vt[0] = {24'h002710, 16'h4000, 16'hC000, 8'h00, 8'h38};
        vt[1] = {24'h000001, 16'h0001, 16'h0001, 8'h01, 8'h05};
        vt[2] = {24'hFFFFFF, 16'hFFFF, 16'hFFFF, 8'h02, 8'hFC};
        vt[3] = {24'h123456, 16'h789A, 16'hBCDE, 8'h03, 8'h4C};
        vt[4] = {24'h800000, 16'h8000, 16'h0080, 8'h04, 8'h85};

        reset = 1'b1;
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        sink_freq = '0; sink_phaseA = '0; sink_phaseB = '0;
        source_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst valid", source_valid, 0);
        check("rst sop", source_sop, 0);
        check("rst eop", source_eop, 0);
        check("rst data", source_data, 0);
        check("rst dropped", dropped, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            ne = 1;
            ef[0] = vt[v].f; ea[0] = vt[v].a; eb[0] = vt[v].b;
            send_frame();
            if (v == 0) begin
                @(negedge clk);
                check("latency valid", source_valid, 1);
                check("latency sop", source_sop, 1);
            end
            recv_pkt($sformatf("vec%0d", v));
            build_exp(vt[v].seq);
`ifndef PEAK_PACKER_CRC_EN
            exp_pkt[exp_pkt.size() - 1] = vt[v].chk;
`endif
            cmp_pkt($sformatf("vec%0d", v));
        end

        // Truncation: six entries, four kept
        rand_entries(6);
        send_frame();
        recv_pkt("trunc");
        check("trunc cnt", pkt[2], 8'h84);
        check("trunc total", pkt.size(), 32);
        build_exp(8'h05);
        cmp_pkt("trunc");

        // Backpressure: two frames buffered, the third dropped
        source_ready = 1'b0;
        drops0 = n_drops;
        for (int f = 0; f < 3; f++) begin
            ne = 1;
            ef[f + 4] = 24'h100000 + 24'(f); ea[f + 4] = 16'h1111 * 16'(f + 1); eb[f + 4] = 16'hA000 + 16'(f);
            ef[0] = ef[f + 4]; ea[0] = ea[f + 4]; eb[0] = eb[f + 4];
            send_frame();
            if (f == 2) begin
                @(negedge clk);
                check("drop pulse", dropped, 1);
            end
            repeat (2) @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drop count", n_drops - drops0, 1);
        source_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            ne = 1;
            ef[0] = ef[f + 4]; ea[0] = ea[f + 4]; eb[0] = eb[f + 4];
            recv_pkt($sformatf("bp%0d", f));
            build_exp(8'h06 + 8'(f));
            cmp_pkt($sformatf("bp%0d", f));
        end
        repeat (20) @(posedge clk);
        #1;
        check("bp no extra pkt", rx_q.size(), 0);

        // Restart: a second sop discards the partial frame
        drops0 = n_drops;
        rand_entries(3);
        drive(1'b1, 1'b0, 0);
        drive(1'b0, 1'b0, 1);
        drive(1'b1, 1'b1, 2);
        recv_pkt("restart");
        ne = 1;
        ef[0] = ef[2]; ea[0] = ea[2]; eb[0] = eb[2];
        build_exp(8'h08);
        cmp_pkt("restart");
        check("restart no drop", n_drops - drops0, 0);

        // Reset in the middle of the payload
        rand_entries(2);
        send_frame();
        t = 0;
        while (rx_q.size() < 5 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("midpay reached", 32'(rx_q.size() >= 5), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst valid", source_valid, 0);
        check("midrst sop", source_sop, 0);
        check("midrst eop", source_eop, 0);
        check("midrst data", source_data, 0);
        check("midrst dropped", dropped, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        rx_q.delete();
        rand_entries(1);
        send_frame();
        recv_pkt("postrst");
        build_exp(8'h00);
        cmp_pkt("postrst");

        // Random backpressure over 300 frames; SEQ wraps
        rand_ready = 1;
        seq = 8'h01;
        pk0 = n_pkts;
        sent = 0;
        exp_all.delete();
        for (int f = 0; f < 300; f++) begin
            t = 0;
            while ((sent - (n_pkts - pk0)) > 1 && t < 2000) begin
                @(posedge clk); #1;
                t++;
            end
            rand_entries(int'($urandom_range(1, 6)));
            build_exp(seq);
            for (int i = 0; i < exp_pkt.size(); i++)
                exp_all.push_back('{sop: (i == 0), eop: (i == exp_pkt.size() - 1), data: exp_pkt[i]});
            send_frame();
            sent++;
            seq = seq + 8'd1;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        t = 0;
        while ((n_pkts - pk0) < 300 && t < 20000) begin
            @(posedge clk); #1;
            t++;
        end
        rand_ready = 0;
        source_ready = 1'b1;
        check("rand pkts", n_pkts - pk0, 300);
        check("rand bytes", rx_q.size(), exp_all.size());
        for (int i = 0; i < exp_all.size(); i++)
            if (i < rx_q.size()) check($sformatf("rand byte%0d", i), rx_q[i], exp_all[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
